icache_param: RTL and testbench
===============================

Name: icache_param

Overview:
- Parametrised, set-associative, read-only instruction cache between the CPU fetch stage and the memory read channel.
- Successor to the fixed 8-set/4-way/256-bit I-cache: sets, ways and line length become parameters, and replacement policy is selectable.
- Adds a whole-cache invalidate handshake (fence.i support) the fixed design lacks.
- Misses fetch one full line as a burst; a refill blocks further requests.

Parameters:
SETS, 8, number of sets (power of 2, >=2)
WAYS, 4, associativity (power of 2, >=1)
LINE_WORDS, 8, 32-bit words per line (power of 2, >=2)
REPL, 1, replacement: 0 = per-set round-robin pointer, 1 = true LRU (per-way age counters)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (state reset when rst==0 at a rising edge)
from_cpu_inst_req_valid  in  1  fetch request valid
from_cpu_inst_req_addr  in  32  fetch address, 4-byte aligned
to_cpu_inst_req_ready  out  1  cache can accept a fetch
to_cpu_cache_rsp_valid  out  1  instruction word valid
to_cpu_cache_rsp_data  out  32  instruction word
from_cpu_cache_rsp_ready  in  1  CPU accepts the response
to_mem_rd_req_valid  out  1  line read request valid
to_mem_rd_req_addr  out  32  line-aligned address; low log2(LINE_WORDS*4) bits are 0
from_mem_rd_req_ready  in  1  memory accepts the request
from_mem_rd_rsp_valid  in  1  data beat valid
from_mem_rd_rsp_data  in  32  data beat
from_mem_rd_rsp_last  in  1  final beat of the burst
to_mem_rd_rsp_ready  out  1  cache accepts the beat
inv_req_valid  in  1  invalidate-all request
inv_req_ready  out  1  invalidate accepted
inv_done  out  1  one-cycle pulse when the invalidate completes

Behaviour:
- Address split: OFF = log2(LINE_WORDS*4), IDX = log2(SETS), TAG = 32-OFF-IDX.
- With the defaults, offset = addr[4:0], index = addr[7:5], tag = addr[31:8].
- Word select is addr[OFF-1:2].
- Reset (rst==0):
  - All valid bits cleared; round-robin pointers and LRU ages set to 0; FSM enters IDLE.
  - All handshake outputs and inv_done are 0, except to_cpu_inst_req_ready = 1 and inv_req_ready = 1 in IDLE.
  - Reset mid-refill abandons the burst. Remaining beats arriving after reset are the memory's responsibility.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP, INV.
- IDLE:
  - req_ready = 1 and inv_req_ready = 1.
  - If inv_req_valid is high, go to INV; invalidate has priority over a simultaneous fetch, and req_ready is deasserted that cycle.
  - Else, on a fetch handshake, latch the address and go to LOOKUP.
- LOOKUP (1 cycle):
  - Compare the tag against all WAYS of the indexed set.
  - Hit: update replacement state, latch the word, go to RESP.
  - Miss: choose a victim. The lowest-numbered invalid way is preferred. Otherwise REPL=0 uses the set's pointer, and REPL=1 uses the way with the largest age.
  - On a miss, go to MISS_REQ.
- Hit latency: response valid 2 cycles after the request handshake edge.
- MISS_REQ: assert mem_rd_req_valid with the line address; hold it stable until from_mem_rd_req_ready, then go to REFILL.
- REFILL:
  - rsp_ready = 1; beats are written in order into a line buffer by a beat counter (width log2(LINE_WORDS)).
  - The counter saturates; beats beyond LINE_WORDS are accepted and discarded.
  - On a beat with last=1: write the buffer, tag and valid bit to the victim way.
  - Also on the last beat: REPL=0 advances the set pointer mod WAYS; REPL=1 zeroes the victim's age and increments, saturating, the ages of the other valid ways in the set.
  - Then go to RESP, returning the requested word from the buffer.
  - If last arrives before LINE_WORDS beats, the unfilled words are undefined, but the line is still marked valid.
- RESP: rsp_valid = 1 with data held stable until from_cpu_cache_rsp_ready, then go to IDLE. No new request is accepted in the same cycle.
- LRU on hit: the hit way's age is set to 0; other ways in the set with age below the hit way's old age are incremented.
- INV: clear the valid bits of one set per cycle for SETS cycles. inv_done pulses in the final INV cycle, then go to IDLE. Replacement state is also reset.
- Outside IDLE: req_ready = 0 and inv_req_ready = 0.

Decomposition:
- Package icache_pkg:
  - FSM state encoding.
  - Localparam functions for OFF, IDX, TAG and the age width log2(WAYS).
  - Line address helper: {tag, idx, OFF'b0}.
- One sub-module, icache_repl: per-set round-robin pointer or LRU age array.
  - Inputs: set index, hit/fill way, update strobe, invalidate.
  - Output: victim way.
- Tag/data/valid arrays are regs in the top.

Test Plan:
1. Cold miss at 0x0000_1040 (defaults): one mem request to 0x0000_1040, 8 beats 0xA0..0xA7 -> rsp_data = 0xA0. A repeat fetch of 0x0000_1044 hits with no mem request; rsp_data = 0xA1, 2 cycles after the handshake.
2. Fill set 2 with lines at 0x040, 0x140, 0x240, 0x340, touch 0x040 again, then fetch 0x440 with REPL=1 -> victim holds 0x140. A refetch of 0x140 misses and 0x040 still hits. With REPL=0 the same sequence evicts 0x040.
3. Backpressure: hold from_mem_rd_req_ready = 0 for 5 cycles -> req_valid and req_addr remain stable. Hold from_cpu_cache_rsp_ready = 0 for 3 cycles -> rsp_valid and rsp_data remain stable.
4. Assert inv_req_valid and a fetch together in IDLE -> invalidate wins. inv_done pulses after exactly SETS=8 cycles, and a refetch of 0x1040 then misses.
5. Assert rst=0 during beat 4 of a refill -> outputs return to reset values. A subsequent fetch of the same address misses and issues a new request.
6. Parameter sweep SETS=16, WAYS=2, LINE_WORDS=4 -> line address low 4 bits are zero and index is addr[7:4]. Hit/miss sequence from scenario 1 passes.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the parametrised instruction cache.
//   state_t   : controller state encoding
//   off_bits  : byte-offset width of a line address (log2(LINE_WORDS*4))
//   idx_bits  : set-index width (log2(SETS))
//   tag_bits  : tag width (32 - offset - index)
//   age_bits  : LRU age / way-index width (log2(WAYS), at least 1)
//   line_addr : line-aligned address {tag, idx, OFF'b0}
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_RESP,
        S_INV
    } state_t;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int sets, input int line_words);
        return 32 - off_bits(line_words) - idx_bits(sets);
    endfunction

    function automatic int age_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Clearing the low OFF bits leaves exactly {tag, idx, OFF'b0}.
    function automatic logic [31:0] line_addr(input logic [31:0] addr, input int off);
        return (addr >> off) << off;
    endfunction

endpackage

// File: rtl/icache_repl.sv
// Replacement state for the instruction cache.
//   REPL = 0 : one round-robin pointer per set, advanced on every fill.
//   REPL = 1 : one age counter per way (0 = most recently used).
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   set_idx     : set being looked up / filled
//   valid_mask  : valid bits of that set
//   upd_way     : hit way (with hit_upd) or filled way (with fill_upd)
//   hit_upd     : lookup hit in set_idx
//   fill_upd    : refill of upd_way completes in set_idx
//   inv         : clear all replacement state
//   victim      : way to replace on a miss in set_idx
module icache_repl
    import icache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 4,
    parameter int REPL = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [idx_bits(SETS)-1:0]   set_idx,
    input  logic [WAYS-1:0]             valid_mask,
    input  logic [age_bits(WAYS)-1:0]   upd_way,
    input  logic                        hit_upd,
    input  logic                        fill_upd,
    input  logic                        inv,
    output logic [age_bits(WAYS)-1:0]   victim
);

    localparam int WB = age_bits(WAYS);

    logic          inv_found;
    logic [WB-1:0] inv_way;
    logic [WB-1:0] pol_way;

    // Lowest-numbered invalid way always wins over the policy choice.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mask[w]) begin
                inv_found = 1'b1;
                inv_way   = WB'(w);
            end
        end
    end

    assign victim = inv_found ? inv_way : pol_way;

    if (REPL == 0) begin : g_rr
        logic [WB-1:0] ptr [SETS];
        logic          rr_unused;

        // The pointer ignores hits and the filled way.
        assign rr_unused = ^{hit_upd, upd_way};
        assign pol_way   = ptr[set_idx];

        always_ff @(posedge clk) begin
            if (!rst || inv) begin
                for (int s = 0; s < SETS; s++) ptr[s] <= '0;
            end else if (fill_upd) begin
                ptr[set_idx] <= (ptr[set_idx] == WB'(WAYS - 1)) ? '0 : ptr[set_idx] + 1'b1;
            end
        end
    end else begin : g_lru
        localparam logic [WB-1:0] AGE_MAX = WB'(WAYS - 1);
        logic [WB-1:0] age [SETS][WAYS];
        logic [WB-1:0] best;

        // Oldest way; strict compare keeps the lowest index on a tie.
        always_comb begin
            pol_way = '0;
            best    = age[set_idx][0];
            for (int w = 1; w < WAYS; w++) begin
                if (age[set_idx][w] > best) begin
                    best    = age[set_idx][w];
                    pol_way = WB'(w);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst || inv) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
            end else if (hit_upd) begin
                // Only ways younger than the hit way age, so ages stay a permutation.
                for (int w = 0; w < WAYS; w++) begin
                    if (WB'(w) == upd_way)
                        age[set_idx][w] <= '0;
                    else if (age[set_idx][w] < age[set_idx][upd_way])
                        age[set_idx][w] <= age[set_idx][w] + 1'b1;
                end
            end else if (fill_upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WB'(w) == upd_way)
                        age[set_idx][w] <= '0;
                    else if (valid_mask[w] && age[set_idx][w] != AGE_MAX)
                        age[set_idx][w] <= age[set_idx][w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/icache_param.sv
// Parametrised set-associative read-only instruction cache.
// Ports:
//   clk, rst                        : clock, synchronous active-low reset
//   from_cpu_inst_req_*             : fetch request (valid/addr) in, ready out
//   to_cpu_cache_rsp_*              : instruction word (valid/data) out, ready in
//   to_mem_rd_req_*                 : line read request (valid/addr) out, ready in
//   from_mem_rd_rsp_*               : refill beats (valid/data/last) in, ready out
//   inv_req_valid / inv_req_ready   : whole-cache invalidate handshake
//   inv_done                        : one-cycle pulse in the final invalidate cycle
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; a producer holds valid and its payload stable until that edge.
module icache_param
    import icache_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 8,
    parameter int REPL       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cpu_inst_req_valid,
    input  logic [31:0] from_cpu_inst_req_addr,
    output logic        to_cpu_inst_req_ready,
    output logic        to_cpu_cache_rsp_valid,
    output logic [31:0] to_cpu_cache_rsp_data,
    input  logic        from_cpu_cache_rsp_ready,
    output logic        to_mem_rd_req_valid,
    output logic [31:0] to_mem_rd_req_addr,
    input  logic        from_mem_rd_req_ready,
    input  logic        from_mem_rd_rsp_valid,
    input  logic [31:0] from_mem_rd_rsp_data,
    input  logic        from_mem_rd_rsp_last,
    output logic        to_mem_rd_rsp_ready,
    input  logic        inv_req_valid,
    output logic        inv_req_ready,
    output logic        inv_done
);

    localparam int OFF = off_bits(LINE_WORDS);
    localparam int IW  = idx_bits(SETS);
    localparam int TW  = tag_bits(SETS, LINE_WORDS);
    localparam int WW  = OFF - 2;
    localparam int WB  = age_bits(WAYS);

    state_t        state;
    logic [31:0]   req_addr_q;
    logic [31:0]   rsp_data_q;
    logic [WB-1:0] victim, victim_q;
    logic [WW-1:0] beat_cnt;
    logic          buf_full;
    logic [IW-1:0] inv_cnt;

    logic [TW-1:0]   tag_arr   [SETS][WAYS];
    logic [WAYS-1:0] valid_arr [SETS];
    logic [31:0]     data_arr  [SETS][WAYS][LINE_WORDS];
    logic [31:0]     line_buf  [LINE_WORDS];
    logic [31:0]     fill_line [LINE_WORDS];

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [WW-1:0] req_word;
    logic          hit;
    logic [WB-1:0] hit_way;
    logic          beat_fire;
    logic          fill_last;

    assign req_tag  = req_addr_q[31 -: TW];
    assign req_idx  = req_addr_q[OFF +: IW];
    assign req_word = req_addr_q[2 +: WW];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    assign beat_fire = (state == S_REFILL) && from_mem_rd_rsp_valid;
    assign fill_last = beat_fire && from_mem_rd_rsp_last;

    // Completed line including the beat arriving this cycle; once the buffer
    // is full, extra beats are dropped.
    always_comb begin
        for (int w = 0; w < LINE_WORDS; w++) begin
            fill_line[w] = (!buf_full && beat_cnt == WW'(w)) ? from_mem_rd_rsp_data : line_buf[w];
        end
    end

    icache_repl #(
        .SETS (SETS),
        .WAYS (WAYS),
        .REPL (REPL)
    ) u_repl (
        .clk        (clk),
        .rst        (rst),
        .set_idx    (req_idx),
        .valid_mask (valid_arr[req_idx]),
        .upd_way    ((state == S_LOOKUP) ? hit_way : victim_q),
        .hit_upd    ((state == S_LOOKUP) && hit),
        .fill_upd   (fill_last),
        .inv        (state == S_INV),
        .victim     (victim)
    );

    // Data storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (beat_fire && !buf_full) line_buf[beat_cnt] <= from_mem_rd_rsp_data;
        if (rst && fill_last) begin
            for (int w = 0; w < LINE_WORDS; w++) data_arr[req_idx][victim_q][w] <= fill_line[w];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_addr_q <= '0;
            rsp_data_q <= '0;
            victim_q   <= '0;
            beat_cnt   <= '0;
            buf_full   <= 1'b0;
            inv_cnt    <= '0;
            for (int s = 0; s < SETS; s++) valid_arr[s] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inv_req_valid) begin
                        inv_cnt <= '0;
                        state   <= S_INV;
                    end else if (from_cpu_inst_req_valid) begin
                        req_addr_q <= from_cpu_inst_req_addr;
                        state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        rsp_data_q <= data_arr[req_idx][hit_way][req_word];
                        state      <= S_RESP;
                    end else begin
                        victim_q <= victim;
                        state    <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    beat_cnt <= '0;
                    buf_full <= 1'b0;
                    if (from_mem_rd_req_ready) state <= S_REFILL;
                end
                S_REFILL: begin
                    if (beat_fire) begin
                        if (!buf_full) begin
                            if (beat_cnt == WW'(LINE_WORDS - 1)) buf_full <= 1'b1;
                            else beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (from_mem_rd_rsp_last) begin
                            tag_arr[req_idx][victim_q]   <= req_tag;
                            valid_arr[req_idx][victim_q] <= 1'b1;
                            rsp_data_q                   <= fill_line[req_word];
                            state                        <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (from_cpu_cache_rsp_ready) state <= S_IDLE;
                end
                S_INV: begin
                    valid_arr[inv_cnt] <= '0;
                    if (inv_cnt == IW'(SETS - 1)) state <= S_IDLE;
                    else inv_cnt <= inv_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Invalidate beats a simultaneous fetch, so fetch-ready drops with inv_req_valid.
    assign to_cpu_inst_req_ready  = (state == S_IDLE) && !inv_req_valid;
    assign inv_req_ready          = (state == S_IDLE);
    assign to_cpu_cache_rsp_valid = (state == S_RESP);
    assign to_cpu_cache_rsp_data  = rsp_data_q;
    assign to_mem_rd_req_valid    = (state == S_MISS_REQ);
    assign to_mem_rd_req_addr     = line_addr(req_addr_q, OFF);
    assign to_mem_rd_rsp_ready    = (state == S_REFILL);
    assign inv_done               = (state == S_INV) && (inv_cnt == IW'(SETS - 1));

endmodule

// File: tb/tb_icache_param.sv
// Bench for icache_param. Three instances share clock and reset:
//   d0 : defaults, true LRU
//   d1 : defaults, round-robin
//   d2 : SETS=16, WAYS=2, LINE_WORDS=4, true LRU
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_icache_param;

    localparam int ND = 3;

    logic        clk;
    logic        rst;
    logic        req_valid  [ND];
    logic [31:0] req_addr   [ND];
    logic        req_ready  [ND];
    logic        rsp_valid  [ND];
    logic [31:0] rsp_data   [ND];
    logic        rsp_ready  [ND];
    logic        mreq_valid [ND];
    logic [31:0] mreq_addr  [ND];
    logic        mreq_ready [ND];
    logic        mrsp_valid [ND];
    logic [31:0] mrsp_data  [ND];
    logic        mrsp_last  [ND];
    logic        mrsp_ready [ND];
    logic        inv_valid  [ND];
    logic        inv_ready  [ND];
    logic        inv_done   [ND];

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < ND; g++) begin : g_dut
        icache_param #(
            .SETS       ((g == 2) ? 16 : 8),
            .WAYS       ((g == 2) ? 2 : 4),
            .LINE_WORDS ((g == 2) ? 4 : 8),
            .REPL       ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk                      (clk),
            .rst                      (rst),
            .from_cpu_inst_req_valid  (req_valid[g]),
            .from_cpu_inst_req_addr   (req_addr[g]),
            .to_cpu_inst_req_ready    (req_ready[g]),
            .to_cpu_cache_rsp_valid   (rsp_valid[g]),
            .to_cpu_cache_rsp_data    (rsp_data[g]),
            .from_cpu_cache_rsp_ready (rsp_ready[g]),
            .to_mem_rd_req_valid      (mreq_valid[g]),
            .to_mem_rd_req_addr       (mreq_addr[g]),
            .from_mem_rd_req_ready    (mreq_ready[g]),
            .from_mem_rd_rsp_valid    (mrsp_valid[g]),
            .from_mem_rd_rsp_data     (mrsp_data[g]),
            .from_mem_rd_rsp_last     (mrsp_last[g]),
            .to_mem_rd_rsp_ready      (mrsp_ready[g]),
            .inv_req_valid            (inv_valid[g]),
            .inv_req_ready            (inv_ready[g]),
            .inv_done                 (inv_done[g])
        );
    end

    // ------------------------------------------------------------ scoreboard
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        int          ph;        // phase the vector belongs to
        int          d;         // instance
        logic [31:0] addr;      // fetch address
        bit          miss;      // expect a memory request
        logic [31:0] maddr;     // expected line address
        logic [31:0] base;      // beat i carries base+i
        int          nbeats;    // beats supplied, last flagged on the final one
        logic [31:0] data;      // expected instruction word
        int          req_hold;  // cycles memory withholds req ready
        int          rsp_hold;  // cycles CPU withholds rsp ready
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int ph, input int d, input logic [31:0] addr, input bit miss,
                       input logic [31:0] maddr, input logic [31:0] base, input int nbeats,
                       input logic [31:0] data, input int req_hold, input int rsp_hold);
        vec_t v;
        v = '{ph, d, addr, miss, maddr, base, nbeats, data, req_hold, rsp_hold};
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------ drivers
    task automatic do_fetch(input vec_t v, input string nm);
        int n;
        int d;
        d = v.d;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = v.addr;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, ".req_ready"}, 32'(req_ready[d]), 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = '0;
        // Hit response and miss request both surface at the second sample
        // after the request handshake edge.
        n = 1;
        while (!rsp_valid[d] && !mreq_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, ".latency"}, 32'(n), 32'd2);
        check({nm, ".miss"}, 32'(mreq_valid[d]), 32'(v.miss));
        if (mreq_valid[d]) begin
            check({nm, ".mem_addr"}, mreq_addr[d], v.maddr);
            for (int h = 0; h < v.req_hold; h++) begin
                @(negedge clk);
                check($sformatf("%s.mreq_hold%0d_valid", nm, h), 32'(mreq_valid[d]), 32'd1);
                check($sformatf("%s.mreq_hold%0d_addr", nm, h), mreq_addr[d], v.maddr);
            end
            mreq_ready[d] = 1'b1;
            @(negedge clk);
            mreq_ready[d] = 1'b0;
            check({nm, ".mreq_dropped"}, 32'(mreq_valid[d]), 32'd0);
            check({nm, ".mrsp_ready"}, 32'(mrsp_ready[d]), 32'd1);
            for (int i = 0; i < v.nbeats; i++) begin
                mrsp_valid[d] = 1'b1;
                mrsp_data[d]  = v.base + 32'(i);
                mrsp_last[d]  = (i == v.nbeats - 1);
                @(negedge clk);
            end
            mrsp_valid[d] = 1'b0;
            mrsp_last[d]  = 1'b0;
            mrsp_data[d]  = '0;
        end
        check({nm, ".rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
        check({nm, ".rsp_data"}, rsp_data[d], v.data);
        for (int h = 0; h < v.rsp_hold; h++) begin
            @(negedge clk);
            check($sformatf("%s.rsp_hold%0d_valid", nm, h), 32'(rsp_valid[d]), 32'd1);
            check($sformatf("%s.rsp_hold%0d_data", nm, h), rsp_data[d], v.data);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check({nm, ".rsp_done"}, 32'(rsp_valid[d]), 32'd0);
    endtask

    task automatic run_phase(input int ph);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].ph == ph) do_fetch(vecs[i], $sformatf("p%0d_v%0d", ph, i));
        end
    endtask

    // Invalidate on d0 (8 sets), optionally racing a fetch.
    task automatic do_inv(input bit with_fetch, input logic [31:0] faddr, input string nm);
        @(negedge clk);
        inv_valid[0] = 1'b1;
        if (with_fetch) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = faddr;
        end
        #1;
        check({nm, ".inv_ready"}, 32'(inv_ready[0]), 32'd1);
        check({nm, ".req_ready_low"}, 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        inv_valid[0] = 1'b0;
        req_valid[0] = 1'b0;
        req_addr[0]  = '0;
        check({nm, ".busy"}, 32'(inv_ready[0]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("%s.inv_done_c%0d", nm, k), 32'(inv_done[0]), 32'(k == 8));
            @(negedge clk);
        end
        check({nm, ".done_cleared"}, 32'(inv_done[0]), 32'd0);
        check({nm, ".idle_req_ready"}, 32'(req_ready[0]), 32'd1);
        check({nm, ".no_rsp"}, 32'(rsp_valid[0]), 32'd0);
        check({nm, ".no_mreq"}, 32'(mreq_valid[0]), 32'd0);
    endtask

    task automatic check_reset_outputs(input int d, input string nm);
        check({nm, ".req_ready"}, 32'(req_ready[d]), 32'd1);
        check({nm, ".inv_ready"}, 32'(inv_ready[d]), 32'd1);
        check({nm, ".rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({nm, ".mreq_valid"}, 32'(mreq_valid[d]), 32'd0);
        check({nm, ".mrsp_ready"}, 32'(mrsp_ready[d]), 32'd0);
        check({nm, ".inv_done"}, 32'(inv_done[d]), 32'd0);
    endtask

    // Reset asserted together with beat 4 of a refill on d0.
    task automatic reset_mid_refill();
        int n;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0000_2000;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (!mreq_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid.miss", 32'(mreq_valid[0]), 32'd1);
        check("rst_mid.mem_addr", mreq_addr[0], 32'h0000_2000);
        mreq_ready[0] = 1'b1;
        @(negedge clk);
        mreq_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mrsp_valid[0] = 1'b1;
            mrsp_data[0]  = 32'h90 + 32'(i);
            @(negedge clk);
        end
        mrsp_valid[0] = 1'b1;
        mrsp_data[0]  = 32'h94;
        rst = 1'b0;
        @(negedge clk);
        mrsp_valid[0] = 1'b0;
        mrsp_data[0]  = '0;
        check_reset_outputs(0, "rst_mid");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------ test
    initial begin
        // Phase 1: set-2 replacement on the LRU and round-robin instances,
        // then the SETS=16/WAYS=2/LINE_WORDS=4 instance.
        add(1, 0, 32'h040, 1, 32'h040, 32'h100, 8, 32'h100, 0, 0);
        add(1, 0, 32'h140, 1, 32'h140, 32'h200, 8, 32'h200, 0, 0);
        add(1, 0, 32'h240, 1, 32'h240, 32'h300, 8, 32'h300, 0, 0);
        add(1, 0, 32'h340, 1, 32'h340, 32'h400, 8, 32'h400, 0, 0);
        add(1, 0, 32'h040, 0, 32'h0,   32'h0,   0, 32'h100, 0, 0);
        add(1, 0, 32'h440, 1, 32'h440, 32'h500, 8, 32'h500, 0, 0);  // evicts 0x140
        add(1, 0, 32'h040, 0, 32'h0,   32'h0,   0, 32'h100, 0, 0);
        add(1, 0, 32'h14C, 1, 32'h140, 32'h600, 8, 32'h603, 0, 0);
        add(1, 1, 32'h040, 1, 32'h040, 32'h100, 8, 32'h100, 0, 0);
        add(1, 1, 32'h140, 1, 32'h140, 32'h200, 8, 32'h200, 0, 0);
        add(1, 1, 32'h240, 1, 32'h240, 32'h300, 8, 32'h300, 0, 0);
        add(1, 1, 32'h340, 1, 32'h340, 32'h400, 8, 32'h400, 0, 0);
        add(1, 1, 32'h040, 0, 32'h0,   32'h0,   0, 32'h100, 0, 0);
        add(1, 1, 32'h440, 1, 32'h440, 32'h500, 8, 32'h500, 0, 0);  // evicts 0x040
        add(1, 1, 32'h140, 0, 32'h0,   32'h0,   0, 32'h200, 0, 0);
        add(1, 1, 32'h044, 1, 32'h040, 32'h700, 8, 32'h701, 0, 0);
        add(1, 2, 32'h1040, 1, 32'h1040, 32'hA0, 4, 32'hA0, 0, 0);
        add(1, 2, 32'h1044, 0, 32'h0,    32'h0,  0, 32'hA1, 0, 0);
        add(1, 2, 32'h104C, 0, 32'h0,    32'h0,  0, 32'hA3, 0, 0);
        add(1, 2, 32'h1058, 1, 32'h1050, 32'hB0, 4, 32'hB2, 0, 0);
        add(1, 2, 32'h1048, 0, 32'h0,    32'h0,  0, 32'hA2, 0, 0);
        add(1, 2, 32'h205C, 1, 32'h2050, 32'hC0, 6, 32'hC3, 0, 0);  // two extra beats
        add(1, 2, 32'h2050, 0, 32'h0,    32'h0,  0, 32'hC0, 0, 0);
        add(1, 2, 32'h3004, 1, 32'h3000, 32'hD0, 2, 32'hD1, 0, 0);  // short burst
        add(1, 2, 32'h3000, 0, 32'h0,    32'h0,  0, 32'hD0, 0, 0);
        // Phase 2: cold miss with backpressure on both sides, then hits.
        add(2, 0, 32'h1040, 1, 32'h1040, 32'hA0, 8, 32'hA0, 5, 3);
        add(2, 0, 32'h1044, 0, 32'h0,    32'h0,  0, 32'hA1, 0, 0);
        add(2, 0, 32'h105C, 0, 32'h0,    32'h0,  0, 32'hA7, 0, 0);
        // Phase 3: refetch after invalidate misses.
        add(3, 0, 32'h1040, 1, 32'h1040, 32'hE0, 8, 32'hE0, 0, 0);
        // Phase 4: refetch after a reset that abandoned a refill.
        add(4, 0, 32'h2000, 1, 32'h2000, 32'hF0, 8, 32'hF0, 0, 0);

        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            req_valid[d]  = 1'b0;
            req_addr[d]   = '0;
            rsp_ready[d]  = 1'b0;
            mreq_ready[d] = 1'b0;
            mrsp_valid[d] = 1'b0;
            mrsp_data[d]  = '0;
            mrsp_last[d]  = 1'b0;
            inv_valid[d]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) check_reset_outputs(d, $sformatf("reset_d%0d", d));
        rst = 1'b1;
        @(negedge clk);

        run_phase(1);
        do_inv(1'b0, 32'h0, "inv_a");
        run_phase(2);
        do_inv(1'b1, 32'h1044, "inv_b");
        run_phase(3);
        reset_mid_refill();
        run_phase(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
